// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: FSM encoding,
// sequencing limits and a saturating counter helper.
package pipe_pkg;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    localparam int unsigned INIT_CYCLES = 2;
    localparam logic [1:0]  INIT_LAST   = 2'(INIT_CYCLES - 1);
    localparam logic [7:0]  WAIT_LIMIT  = 8'd255;
    localparam logic [15:0] CNT_MAX     = 16'hFFFF;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == CNT_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: the load in EX writes a register the instruction in ID reads.
module hazard_detect (
    input  logic       EX_MemRead_i,
    input  logic [4:0] EX_Rd_i,
    input  logic [4:0] ID_Rs1_i,
    input  logic [4:0] ID_Rs2_i,
    output logic       LoadUse_o
);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign LoadUse_o = EX_MemRead_i && (EX_Rd_i != 5'd0) &&
                       ((EX_Rd_i == ID_Rs1_i) || (EX_Rd_i == ID_Rs2_i));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control: start-up sequencing, load-use stalls, branch flushes,
// memory-wait freezes with a sticky timeout, and saturating event counters.
module pipeline_ctrl
    import pipe_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  ID_Rs1_i,
    input  logic [4:0]  ID_Rs2_i,
    input  logic [4:0]  EX_Rd_i,
    input  logic        EX_MemRead_i,
    input  logic        Branch_i,
    input  logic        MemBusy_i,
    output logic        PCWrite_o,
    output logic        IFIDWrite_o,
    output logic        IFIDFlush_o,
    output logic        IDEXBubble_o,
    output logic        Freeze_o,
    output logic [15:0] StallCnt_o,
    output logic [15:0] FlushCnt_o,
    output logic        Timeout_o
);

    state_e      state_q, state_d;
    logic [1:0]  init_cnt_q, init_cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        timeout_q, timeout_d;
    logic        load_use;

    hazard_detect u_hazard_detect (
        .EX_MemRead_i (EX_MemRead_i),
        .EX_Rd_i      (EX_Rd_i),
        .ID_Rs1_i     (ID_Rs1_i),
        .ID_Rs2_i     (ID_Rs2_i),
        .LoadUse_o    (load_use)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        timeout_d    = timeout_q;
        PCWrite_o    = 1'b0;
        IFIDWrite_o  = 1'b0;
        IFIDFlush_o  = 1'b0;
        IDEXBubble_o = 1'b0;
        Freeze_o     = 1'b0;

        case (state_q)
            INIT: begin
                IDEXBubble_o = 1'b1;
                if (init_cnt_q == INIT_LAST) begin
                    state_d    = RUN;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + 2'd1;
                end
            end

            RUN, MEM_WAIT: begin
                if (MemBusy_i) begin
                    Freeze_o = 1'b1;
                    if (state_q == RUN) begin
                        state_d    = MEM_WAIT;
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = (wait_cnt_q == WAIT_LIMIT) ? wait_cnt_q : wait_cnt_q + 8'd1;
                        timeout_d  = timeout_q || (wait_cnt_d == WAIT_LIMIT);
                    end
                end else begin
                    // Memory released: the normal RUN rules apply in this same cycle.
                    state_d = RUN;
                    if (load_use) begin
                        IDEXBubble_o = 1'b1;
                    end else begin
                        PCWrite_o   = 1'b1;
                        IFIDWrite_o = 1'b1;
                        IFIDFlush_o = Branch_i;
                    end
                end
            end

            default: state_d = INIT;
        endcase

        stall_cnt_d = ((state_q != INIT) && !PCWrite_o) ? sat_inc(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = IFIDFlush_o ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign StallCnt_o = stall_cnt_q;
    assign FlushCnt_o = flush_cnt_q;
    assign Timeout_o  = timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the control rules.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs1 = '0;
    logic [4:0]  id_rs2 = '0;
    logic [4:0]  ex_rd = '0;
    logic        ex_memread = 1'b0;
    logic        branch = 1'b0;
    logic        mem_busy = 1'b0;
    logic        pc_write, ifid_write, ifid_flush, idex_bubble, freeze, timeout;
    logic [15:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    int init_left   = 2;
    bit in_wait     = 1'b0;
    int wait_cycles = 0;
    int m_stall     = 0;
    int m_flush     = 0;
    bit m_tmo       = 1'b0;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ID_Rs1_i     (id_rs1),
        .ID_Rs2_i     (id_rs2),
        .EX_Rd_i      (ex_rd),
        .EX_MemRead_i (ex_memread),
        .Branch_i     (branch),
        .MemBusy_i    (mem_busy),
        .PCWrite_o    (pc_write),
        .IFIDWrite_o  (ifid_write),
        .IFIDFlush_o  (ifid_flush),
        .IDEXBubble_o (idex_bubble),
        .Freeze_o     (freeze),
        .StallCnt_o   (stall_cnt),
        .FlushCnt_o   (flush_cnt),
        .Timeout_o    (timeout)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, compare every output against the model, then advance the model past the edge.
    task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic mr, input logic br, input logic busy);
        logic lu, e_pcw, e_ifw, e_fl, e_bub, e_frz;
        @(negedge clk);
        id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
        ex_memread = mr; branch = br; mem_busy = busy;
        #1;
        lu = mr && (rd != 5'd0) && (rd == rs1 || rd == rs2);
        e_pcw = 1'b0; e_ifw = 1'b0; e_fl = 1'b0; e_bub = 1'b0; e_frz = 1'b0;
        if (init_left > 0) begin
            e_bub = 1'b1;
        end else if (busy) begin
            e_frz = 1'b1;
        end else if (lu) begin
            e_bub = 1'b1;
        end else begin
            e_pcw = 1'b1; e_ifw = 1'b1; e_fl = br;
        end
        check("PCWrite",    32'(pc_write),    32'(e_pcw));
        check("IFIDWrite",  32'(ifid_write),  32'(e_ifw));
        check("IFIDFlush",  32'(ifid_flush),  32'(e_fl));
        check("IDEXBubble", 32'(idex_bubble), 32'(e_bub));
        check("Freeze",     32'(freeze),      32'(e_frz));
        check("StallCnt",   32'(stall_cnt),   32'(m_stall));
        check("FlushCnt",   32'(flush_cnt),   32'(m_flush));
        check("Timeout",    32'(timeout),     32'(m_tmo));
        @(posedge clk);
        if (init_left > 0) begin
            init_left--;
        end else begin
            if (!e_pcw && m_stall < 65535) m_stall++;
            if (e_fl && m_flush < 65535) m_flush++;
            if (busy) begin
                if (in_wait) begin
                    wait_cycles++;
                    if (wait_cycles >= 255) m_tmo = 1'b1;
                end else begin
                    in_wait     = 1'b1;
                    wait_cycles = 0;
                end
            end else begin
                in_wait = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
    endtask

    // Assert reset between edges, confirm outputs respond at once, release shortly after the next edge.
    task automatic apply_reset();
        #3;
        rst = 1'b1;
        #1;
        check("rst_PCWrite",    32'(pc_write),    32'd0);
        check("rst_IFIDWrite",  32'(ifid_write),  32'd0);
        check("rst_IFIDFlush",  32'(ifid_flush),  32'd0);
        check("rst_IDEXBubble", 32'(idex_bubble), 32'd1);
        check("rst_Freeze",     32'(freeze),      32'd0);
        check("rst_StallCnt",   32'(stall_cnt),   32'd0);
        check("rst_FlushCnt",   32'(flush_cnt),   32'd0);
        check("rst_Timeout",    32'(timeout),     32'd0);
        init_left = 2; in_wait = 1'b0; wait_cycles = 0;
        m_stall = 0; m_flush = 0; m_tmo = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int busy_left;
        apply_reset();

        // Start-up: two INIT cycles, then RUN with no stalls recorded
        idle(3);
        #1;
        check("init_stall_zero", 32'(stall_cnt), 32'd0);

        // Load-use on rs2 stalls one cycle; rd = x0 does not
        step(5'd7, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0);
        #1;
        check("lu_stall_one", 32'(stall_cnt), 32'd1);
        step(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        #1;
        check("lu_x0_no_stall", 32'(stall_cnt), 32'd1);

        // Load-use wins over branch
        step(5'd9, 5'd1, 5'd9, 1'b1, 1'b1, 1'b0);
        #1;
        check("lu_branch_no_flush", 32'(flush_cnt), 32'd0);
        check("lu_branch_stall",    32'(stall_cnt), 32'd2);
        step(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0);
        #1;
        check("branch_flush", 32'(flush_cnt), 32'd1);

        // Short memory wait: four frozen cycles
        for (int i = 0; i < 4; i++) step(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1);
        idle(1);
        #1;
        check("memwait4_stall",   32'(stall_cnt), 32'd6);
        check("memwait4_timeout", 32'(timeout),   32'd0);

        // Long memory wait: timeout sets and stays after release
        for (int i = 0; i < 300; i++) step(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1);
        idle(5);
        #1;
        check("timeout_sticky", 32'(timeout), 32'd1);

        // Randomized traffic with occasional memory-busy bursts
        busy_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (busy_left == 0 && $urandom_range(0, 19) == 0) busy_left = $urandom_range(1, 6);
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), busy_left > 0);
            if (busy_left > 0) busy_left--;
        end

        // Reset in the middle of a memory wait clears everything including timeout
        for (int i = 0; i < 3; i++) step(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1);
        apply_reset();
        idle(4);

        // Reset in the middle of INIT restarts the full start-up sequence
        apply_reset();
        idle(1);
        apply_reset();
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Module SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Port list, in this order:
- clk_i  in  1  pipeline clock; all state changes on posedge
- rst_i  in  1  asynchronous active-high reset
- ID_Rs1_i  in  5  rs1 field of instruction in ID
- ID_Rs2_i  in  5  rs2 field of instruction in ID
- EX_Rd_i  in  5  rd field held in ID/EX register
- EX_MemRead_i  in  1  MemRead held in ID/EX register
- Branch_i  in  1  branch taken, resolved in ID
- MemBusy_i  in  1  data memory not ready; level, may last many cycles
- PCWrite_o  out  1  PC update enable
- IFIDWrite_o  out  1  IF/ID register load enable
- IFIDFlush_o  out  1  IF/ID register clear to NOP
- IDEXBubble_o  out  1  force ID/EX control fields to zero
- Freeze_o  out  1  hold ID/EX, EX/MEM, MEM/WB registers
- StallCnt_o  out  16  stall-cycle counter, saturating
- FlushCnt_o  out  16  flush counter, saturating
- Timeout_o  out  1  sticky: memory wait exceeded limit

Function
REQ-003 FSM states SHALL be INIT, RUN, MEM_WAIT.
REQ-004 INIT SHALL last exactly 2 cycles after reset release: PCWrite_o=0, IFIDWrite_o=0, IDEXBubble_o=1, Freeze_o=0; then RUN.
REQ-005 Load-use hazard SHALL be EX_MemRead_i=1 and EX_Rd_i!=0 and (EX_Rd_i==ID_Rs1_i or EX_Rd_i==ID_Rs2_i).
REQ-006 RUN priority SHALL be MemBusy_i > load-use > Branch_i; outputs combinational from state and inputs in that cycle.
REQ-007 RUN, MemBusy_i=1: Freeze_o=1, PCWrite_o=0, IFIDWrite_o=0, no bubble, no flush; next state MEM_WAIT.
REQ-008 RUN, load-use, MemBusy_i=0: PCWrite_o=0, IFIDWrite_o=0, IDEXBubble_o=1 for that cycle only; Branch_i ignored that cycle; stay RUN.
REQ-009 RUN, Branch_i=1, no higher-priority event: IFIDFlush_o=1, PCWrite_o=1, IFIDWrite_o=1; FlushCnt_o +1.
REQ-010 RUN, no event: PCWrite_o=1, IFIDWrite_o=1, all other strobes 0.
REQ-011 MEM_WAIT: Freeze_o=1, PCWrite_o=0, IFIDWrite_o=0, IDEXBubble_o=0, IFIDFlush_o=0 while MemBusy_i=1; on MemBusy_i=0 return to RUN and apply RUN rules in that same cycle.
REQ-012 MEM_WAIT SHALL run an 8-bit wait counter cleared on entry; when it reaches 255, Timeout_o SHALL set and remain 1 until reset; FSM stays in MEM_WAIT until MemBusy_i=0.
REQ-013 StallCnt_o SHALL +1 every cycle PCWrite_o=0 in RUN or MEM_WAIT (not INIT); both counters saturate at 16'hFFFF.
REQ-014 IFIDFlush_o and IFIDWrite_o=0 SHALL never assert together with IDEXBubble_o=0 and Freeze_o=0 while PCWrite_o=1 except per REQ-009.

Reset
REQ-015 rst_i=1 SHALL immediately force state INIT, counters 0, Timeout_o=0, wait counter 0.
REQ-016 During reset outputs SHALL be PCWrite_o=0, IFIDWrite_o=0, IFIDFlush_o=0, IDEXBubble_o=1, Freeze_o=0.
REQ-017 Reset asserted mid-MEM_WAIT or mid-INIT SHALL abandon the sequence; INIT restarts with full 2 cycles after release.

Structure
REQ-018 State encoding (INIT=2'd0, RUN=2'd1, MEM_WAIT=2'd2), INIT_CYCLES=2 and WAIT_LIMIT=8'd255 SHALL live in shared package pipe_pkg.
REQ-019 Hazard compare (REQ-005) SHALL be sub-module hazard_detect, purely combinational, output LoadUse.

Verification
REQ-020 Reset release, no events -> PCWrite_o=0 for cycles 1-2, PCWrite_o=1 from cycle 3; StallCnt_o=0.
REQ-021 RUN, EX_MemRead_i=1, EX_Rd_i=5, ID_Rs2_i=5 -> one cycle PCWrite_o=0, IDEXBubble_o=1; StallCnt_o=1; same with EX_Rd_i=0 -> no stall.
REQ-022 Load-use and Branch_i=1 same cycle -> bubble only, IFIDFlush_o=0, FlushCnt_o unchanged.
REQ-023 MemBusy_i high 4 cycles -> Freeze_o=1 for 4 cycles, StallCnt_o=4, Timeout_o=0.
REQ-024 MemBusy_i high 300 cycles -> Timeout_o=1 after 255 wait cycles, stays 1 after MemBusy_i drops, cleared only by rst_i.
REQ-025 rst_i pulse during MEM_WAIT -> outputs to reset values immediately, INIT 2 cycles, counters 0.
